// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_sched_pkg;

   // Scheduler FSM states
   typedef enum logic [3:0] {
      ST_OFF       = 4'd0,
      ST_CFG_BRG   = 4'd1,
      ST_CFG_TX    = 4'd2,
      ST_IDLE      = 4'd3,
      ST_LOAD      = 4'd4,
      ST_WAIT_LOW  = 4'd5,
      ST_WAIT_HIGH = 4'd6,
      ST_DRAIN     = 4'd7,
      ST_SHUT      = 4'd8
   } state_e;

   // TXSTA bit positions
   localparam int TXSTA_TX9  = 6;
   localparam int TXSTA_TXEN = 5;
   localparam int TXSTA_SYNC = 4;
   localparam int TXSTA_BRGH = 2;
   localparam int TXSTA_TRMT = 1;
   localparam int TXSTA_TX9D = 0;

   // TXSTA value for async 8-bit transmit with TXEN set and the chosen BRGH
   function automatic logic [7:0] txsta_cfg(input logic brgh);
      logic [7:0] v;
      v             = 8'h00;
      v[TXSTA_TX9]  = 1'b0;
      v[TXSTA_TXEN] = 1'b1;
      v[TXSTA_SYNC] = 1'b0;
      v[TXSTA_BRGH] = brgh;
      v[TXSTA_TX9D] = 1'b0;
      return v;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Producer handshake and UART register-port bundle for the scheduler.
interface uart_tx_sched_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           uart_wdata;
   logic                 spbrg_wr_en;
   logic                 txsta_wr_en;
   logic                 txreg_wr_en;
   logic [7:0]           txsta_rd;
   logic                 txif;

   // Scheduler side
   modport master (
      input  req_valid, req_data, txsta_rd, txif,
      output req_ready, uart_wdata, spbrg_wr_en, txsta_wr_en, txreg_wr_en
   );

   // Producers plus UART side
   modport slave (
      output req_valid, req_data, txsta_rd, txif,
      input  req_ready, uart_wdata, spbrg_wr_en, txsta_wr_en, txreg_wr_en
   );
endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping modulo NUM_REQ.
module uart_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant_oh,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       any_valid
);
   localparam int PW = $clog2(NUM_REQ);

   logic found;

   // Scan NUM_REQ slots starting at ptr; wrap by subtraction so non-power-of-two counts work
   always_comb begin
      int j;
      j         = 0;
      found     = 1'b0;
      grant_oh  = '0;
      grant_idx = '0;
      any_valid = |req_valid;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req_valid[j]) begin
            found       = 1'b1;
            grant_oh[j] = 1'b1;
            grant_idx   = PW'(j);
         end
      end
   end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Configures the async UART transmitter and shares TXREG among NUM_REQ byte producers.
module uart_tx_scheduler
   import uart_tx_sched_pkg::*;
#(
   parameter int         NUM_REQ    = 4,
   parameter logic [7:0] SPBRG_INIT = 8'd25,
   parameter logic       BRGH_INIT  = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   uart_tx_sched_if.master            bus,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] last_grant,
   output logic                       tx_err
);
   localparam int PW = $clog2(NUM_REQ);

   state_e            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     last_grant_q, last_grant_d;
   logic [NUM_REQ-1:0] ready_q, ready_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              spbrg_q, spbrg_d;
   logic              txsta_q, txsta_d;
   logic              txreg_q, txreg_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic [NUM_REQ-1:0] grant_oh;
   logic [PW-1:0]      grant_idx;
   logic               any_valid;
   logic               grant_take;
   logic               trmt;
   logic               unused_txsta;

   uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_valid (bus.req_valid),
      .ptr       (ptr_q),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .any_valid (any_valid)
   );

   assign trmt         = bus.txsta_rd[TXSTA_TRMT];
   assign unused_txsta = ^{bus.txsta_rd[7:2], bus.txsta_rd[0]};
   assign grant_take   = (state_q == ST_IDLE) && enable && bus.txif && any_valid;

   // State and registered outputs; rst returns everything to its idle value
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_OFF;
         ptr_q        <= '0;
         last_grant_q <= '0;
         ready_q      <= '0;
         wdata_q      <= 8'h00;
         spbrg_q      <= 1'b0;
         txsta_q      <= 1'b0;
         txreg_q      <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         last_grant_q <= last_grant_d;
         ready_q      <= ready_d;
         wdata_q      <= wdata_d;
         spbrg_q      <= spbrg_d;
         txsta_q      <= txsta_d;
         txreg_q      <= txreg_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   // Next-state: configure, serve one byte per TXIF cycle, drain on disable
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF:       if (enable) state_d = ST_CFG_BRG;
         ST_CFG_BRG:   state_d = ST_CFG_TX;
         ST_CFG_TX:    state_d = ST_IDLE;
         ST_IDLE: begin
            if (!enable)         state_d = ST_DRAIN;
            else if (grant_take) state_d = ST_LOAD;
         end
         ST_LOAD:      state_d = ST_WAIT_LOW;
         // UART must have dropped TXIF the edge after our write
         ST_WAIT_LOW:  state_d = bus.txif ? ST_IDLE : ST_WAIT_HIGH;
         ST_WAIT_HIGH: if (bus.txif) state_d = ST_IDLE;
         ST_DRAIN: begin
            if (enable)    state_d = ST_IDLE;
            else if (trmt) state_d = ST_SHUT;
         end
         ST_SHUT:      state_d = ST_OFF;
         default:      state_d = ST_OFF;
      endcase
   end

   // Outputs are decoded from the next state so the flops line up with the state they belong to
   always_comb begin
      spbrg_d      = 1'b0;
      txsta_d      = 1'b0;
      txreg_d      = 1'b0;
      ready_d      = '0;
      wdata_d      = wdata_q;
      ptr_d        = ptr_q;
      last_grant_d = last_grant_q;
      err_d        = err_q | ((state_q == ST_WAIT_LOW) && bus.txif);
      busy_d       = !((state_d == ST_OFF) || (state_d == ST_IDLE));
      case (state_d)
         ST_CFG_BRG: begin
            spbrg_d = 1'b1;
            wdata_d = SPBRG_INIT;
         end
         ST_CFG_TX: begin
            txsta_d = 1'b1;
            wdata_d = txsta_cfg(BRGH_INIT);
         end
         ST_LOAD: begin
            txreg_d      = 1'b1;
            wdata_d      = bus.req_data[8*int'(grant_idx) +: 8];
            ready_d      = grant_oh;
            last_grant_d = grant_idx;
            ptr_d        = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
         end
         ST_SHUT: begin
            txsta_d = 1'b1;
            wdata_d = 8'h00;
         end
         default: ;
      endcase
   end

   assign bus.req_ready   = ready_q;
   assign bus.uart_wdata  = wdata_q;
   assign bus.spbrg_wr_en = spbrg_q;
   assign bus.txsta_wr_en = txsta_q;
   assign bus.txreg_wr_en = txreg_q;
   assign busy            = busy_q;
   assign last_grant      = last_grant_q;
   assign tx_err          = err_q;

endmodule
